// File: rtl/poly_byte_encoder_if.sv
// Coefficient-in / byte-out handshake bundle for poly_byte_encoder.
// slave: the encoder side; master: the source/sink side.
interface poly_byte_encoder_if;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport slave (
    input  coef_in,
    input  coef_valid,
    input  byte_ready,
    output coef_ready,
    output byte_out,
    output byte_valid
  );

  modport master (
    output coef_in,
    output coef_valid,
    output byte_ready,
    input  coef_ready,
    input  byte_out,
    input  byte_valid
  );
endinterface

// File: rtl/poly_byte_encoder.sv
// Streaming ByteEncode_d packer: d-bit coefficients in, LSB-first bytes out.
// Optional macro ENCODE_MODQ_EN: subtract KYBER_Q once from inputs >= q at d=12.
module poly_byte_encoder #(
  parameter int D_MAX   = 12,
  parameter int N_COEF  = 256,
  parameter int KYBER_Q = 3329
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           d_sel,
  poly_byte_encoder_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int ACC_W  = D_MAX + 7;
  localparam int BITS_W = $clog2(ACC_W + 1);
  localparam int CNT_W  = $clog2(N_COEF + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BITS_W-1:0]   acc_bits_q, acc_bits_d;
  logic [CNT_W-1:0]    coef_cnt_q, coef_cnt_d;
  logic [3:0]          d_r_q, d_r_d;
  logic                err_q, err_d;

  logic                run;
  logic                byte_valid_w;
  logic                emit;
  logic                coef_ready_w;
  logic                accept;
  logic                done_w;
  logic                d_legal;
  logic [15:0]         coef_red;
  logic [15:0]         coef_mask;
  logic [ACC_W-1:0]    masked;
  logic [BITS_W-1:0]   d_ext;

  // Handshake decode and coefficient conditioning for the current cycle.
  always_comb begin
    run          = (state_q == RUN);
    byte_valid_w = run && (acc_bits_q >= BITS_W'(8));
    emit         = byte_valid_w && bus.byte_ready;
    coef_ready_w = run
                && (coef_cnt_q < CNT_W'(N_COEF))
                && ((acc_bits_q < BITS_W'(8))
                 || (emit && (acc_bits_q < BITS_W'(16))));
    accept       = coef_ready_w && bus.coef_valid;
    done_w       = run
                && (coef_cnt_q == CNT_W'(N_COEF))
                && (acc_bits_q == '0);
    d_legal      = (d_sel != 4'd0) && (int'(d_sel) <= D_MAX);
    d_ext        = BITS_W'(d_r_q);
    coef_red     = bus.coef_in;
`ifdef ENCODE_MODQ_EN
    if ((d_r_q == 4'd12) && (bus.coef_in >= 16'(KYBER_Q)))
      coef_red = bus.coef_in - 16'(KYBER_Q);
`endif
    coef_mask    = (16'd1 << d_r_q) - 16'd1;
    masked       = ACC_W'(coef_red & coef_mask);
  end

  // Next-state: start/err handling in IDLE, shift/append in RUN.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_bits_d = acc_bits_q;
    coef_cnt_d = coef_cnt_q;
    d_r_d      = d_r_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (d_legal) begin
            state_d    = RUN;
            acc_d      = '0;
            acc_bits_d = '0;
            coef_cnt_d = '0;
            d_r_d      = d_sel;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (done_w) begin
          state_d = IDLE;
        end else if (emit && accept) begin
          acc_d      = (acc_q >> 8)
                     | (masked << (acc_bits_q - BITS_W'(8)));
          acc_bits_d = acc_bits_q + d_ext - BITS_W'(8);
          coef_cnt_d = coef_cnt_q + CNT_W'(1);
        end else if (emit) begin
          acc_d      = acc_q >> 8;
          acc_bits_d = acc_bits_q - BITS_W'(8);
        end else if (accept) begin
          acc_d      = acc_q | (masked << acc_bits_q);
          acc_bits_d = acc_bits_q + d_ext;
          coef_cnt_d = coef_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State register; reset discards any partial polynomial.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_bits_q <= '0;
      coef_cnt_q <= '0;
      d_r_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_bits_q <= acc_bits_d;
      coef_cnt_q <= coef_cnt_d;
      d_r_q      <= d_r_d;
      err_q      <= err_d;
    end
  end

  assign bus.coef_ready = coef_ready_w;
  assign bus.byte_valid = byte_valid_w;
  assign bus.byte_out   = acc_q[7:0];
  assign busy           = run;
  assign done           = done_w;
  assign err            = err_q;

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Bench for poly_byte_encoder: vector table, corner sequences, random polys.
// Expected streams come from a bit-placement model of ByteEncode_d.
module tb_poly_byte_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] d_sel;
  logic       busy;
  logic       done;
  logic       err;

  poly_byte_encoder_if bus ();

  poly_byte_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d_sel (d_sel),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int c0;
    int c1;
    int b0;
    int b1;
    int b2;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned coefs[256];
  logic [7:0]  exp_b[384];
  logic [7:0]  got3[3];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, got, got, want, want);
    end
  endtask

  // Stream bit i*d+j holds bit j of coefficient i; byte k/8, bit k%8.
  function automatic void build_model(input int d);
    for (int i = 0; i < 384; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      int unsigned v;
      v = coefs[i] & 32'hFFFF;
`ifdef ENCODE_MODQ_EN
      if (d == 12 && v >= 3329) v = v - 3329;
`endif
      for (int j = 0; j < d; j++) begin
        int k;
        k = i * d + j;
        if (((v >> j) & 1) == 1) exp_b[k / 8][k % 8] = 1'b1;
      end
    end
  endfunction

  task automatic idle_drive();
    start          = 1'b0;
    d_sel          = 4'd0;
    bus.coef_valid = 1'b0;
    bus.coef_in    = 16'h0000;
    bus.byte_ready = 1'b0;
  endtask

  // rmode: 0 always ready, 1 ready 1-in-3, 2 random.
  // vmode: 0 always valid, 1 random.
  task automatic run_poly(input string name, input int d,
                          input int rmode, input int vmode,
                          input int abort_at, input bit poke_start);
    int idx = 0;
    int bidx = 0;
    int bad = 0;
    int unstable = 0;
    int dones = 0;
    int errs = 0;
    int extra_acc = 0;
    int last_hs = -100;
    int done_cyc = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_b = 8'h00;
    for (int i = 0; i < 3; i++) got3[i] = 8'hEE;
    build_model(d);
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = d[3:0];
    @(posedge clk); #1;
    start = 1'b0;
    d_sel = 4'd0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      case (rmode)
        0: bus.byte_ready = 1'b1;
        1: bus.byte_ready = (cyc % 3 == 2);
        default: bus.byte_ready = ($urandom_range(0, 1) == 1);
      endcase
      bus.coef_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.coef_in = (idx < 256) ? coefs[idx][15:0] : 16'hFFFF;
      if (poke_start && cyc == 40) begin
        start = 1'b1;
        d_sel = 4'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk({name, " busy_after_start"}, int'(busy), 1);
        chk({name, " ready_after_start"}, int'(bus.coef_ready), 1);
      end
      if (err) errs++;
      if (prev_stall && (!bus.byte_valid || bus.byte_out != prev_b))
        unstable++;
      if (bus.coef_valid && bus.coef_ready) begin
        if (idx >= 256) extra_acc++;
        else idx++;
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (bidx < 32 * d) begin
          if (bus.byte_out !== exp_b[bidx]) begin
            if (bad == 0)
              $display("FAIL %s byte %0d: got 0x%0h want 0x%0h",
                       name, bidx, bus.byte_out, exp_b[bidx]);
            bad++;
          end
          if (bidx < 3) got3[bidx] = bus.byte_out;
        end else begin
          bad++;
        end
        bidx++;
        last_hs = cyc;
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_b = bus.byte_out;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (abort_at > 0 && bidx == abort_at) break;
      if (done) break;
      @(posedge clk); #1;
    end
    if (abort_at > 0) begin
      chk({name, " bytes_before_abort"}, bidx, abort_at);
      chk({name, " abort_stream_errs"}, bad, 0);
      return;
    end
    chk({name, " stream_errs"}, bad, 0);
    chk({name, " byte_count"}, bidx, 32 * d);
    chk({name, " done_seen"}, dones, 1);
    chk({name, " done_latency"}, done_cyc - last_hs, 1);
    chk({name, " stall_unstable"}, unstable, 0);
    chk({name, " extra_coef_acc"}, extra_acc, 0);
    chk({name, " err_in_run"}, errs, 0);
    @(posedge clk); #1;
    idle_drive();
    @(negedge clk);
    chk({name, " busy_after_done"}, int'(busy), 0);
    chk({name, " done_single"}, int'(done), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, " coef_ready"}, int'(bus.coef_ready), 0);
    chk({name, " byte_valid"}, int'(bus.byte_valid), 0);
    chk({name, " byte_out"}, int'(bus.byte_out), 0);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done"}, int'(done), 0);
    chk({name, " err"}, int'(err), 0);
  endtask

  task automatic bad_start(input string name, input logic [3:0] d);
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = d;
    @(posedge clk); #1;
    start = 1'b0;
    d_sel = 4'd0;
    @(negedge clk);
    chk({name, " err_pulse"}, int'(err), 1);
    chk({name, " busy_stays_0"}, int'(busy), 0);
    @(negedge clk);
    chk({name, " err_one_cycle"}, int'(err), 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{12, 'h123, 'hABC, 'h23, 'hC1, 'hAB};
    tbl[1] = '{8, 'h1FF, 'h34, 'hFF, 'h34, 'h00};
    tbl[2] = '{4, 'hF5, 'h3, 'h35, 'h00, 'h00};
    tbl[3] = '{1, 1, 1, 'h03, 'h00, 'h00};
    tbl[4] = '{10, 'h3FF, 'h001, 'hFF, 'h07, 'h00};
`ifdef ENCODE_MODQ_EN
    tbl[5] = '{12, 3330, 0, 'h01, 'h00, 'h00};
`else
    tbl[5] = '{12, 3330, 0, 'h02, 'h0D, 'h00};
`endif
    tbl[6] = '{5, 'h1F, 'h1F, 'hFF, 'h03, 'h00};

    idle_drive();
    rst = 1'b1;
    bus.byte_ready = 1'b1;
    bus.coef_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_drive();

    for (int t = 0; t < 7; t++) begin
      string nm;
      nm = $sformatf("vec%0d_d%0d", t, tbl[t].d);
      for (int i = 0; i < 256; i++) coefs[i] = 0;
      coefs[0] = tbl[t].c0;
      coefs[1] = tbl[t].c1;
      run_poly(nm, tbl[t].d, 0, 0, 0, 1'b0);
      chk({nm, " b0"}, int'(got3[0]), tbl[t].b0);
      chk({nm, " b1"}, int'(got3[1]), tbl[t].b1);
      chk({nm, " b2"}, int'(got3[2]), tbl[t].b2);
    end

    for (int i = 0; i < 256; i++) coefs[i] = (i % 2 == 0) ? 1 : 0;
    run_poly("d1_alt", 1, 0, 0, 0, 1'b0);
    chk("d1_alt b0", int'(got3[0]), 'h55);

    for (int i = 0; i < 256; i++) coefs[i] = 0;
    coefs[0] = 'h123;
    coefs[1] = 'hABC;
    run_poly("d12_stall3", 12, 1, 0, 0, 1'b0);

    bad_start("start_d0", 4'd0);
    bad_start("start_d13", 4'd13);

    for (int i = 0; i < 256; i++) coefs[i] = $urandom_range(0, 65535);
    run_poly("d12_start_in_run", 12, 0, 0, 0, 1'b1);

    for (int i = 0; i < 256; i++) coefs[i] = $urandom_range(0, 65535);
    run_poly("d10_abort", 10, 2, 1, 100, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.byte_ready = 1'b1;
    bus.coef_valid = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    idle_drive();
    run_poly("d10_after_reset", 10, 2, 1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int d;
      d = $urandom_range(1, 12);
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 1) == 1) coefs[i] = $urandom_range(0, 6657);
        else coefs[i] = $urandom_range(0, 65535);
      end
      run_poly($sformatf("rand%0d_d%0d", r, d), d, 2, 1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_byte_encoder.md
# poly_byte_encoder

Streaming, runtime-configurable ByteEncode_d serializer for Kyber polynomials. It accepts one 16-bit coefficient per handshake, keeps the low `d` bits, and emits a little-endian packed byte stream of exactly 32·d bytes per polynomial. It replaces the flat combinational encoder in the decryption and encapsulation datapaths, where the whole-polynomial array ports cost too much area. It sits between the compress/NTT output buffers and the ciphertext/message byte sinks.

## Interface
- `D_MAX`, 12: largest supported bit width per coefficient; sets accumulator width `ACC_W = D_MAX+7`.
- `N_COEF`, 256: coefficients per polynomial.
- `KYBER_Q`, 3329: modulus used by the optional reduction.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a polynomial; sampled only in IDLE.
- `d_sel`  in  4  bits per coefficient, legal range 1..D_MAX; latched on an accepted `start`.
- `coef_in`  in  16  coefficient (unsigned).
- `coef_valid`  in  1  `coef_in` is valid.
- `coef_ready`  out  1  the block accepts `coef_in` this cycle.
- `byte_out`  out  8  packed byte.
- `byte_valid`  out  1  `byte_out` is valid.
- `byte_ready`  in  1  the sink accepts `byte_out`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `err`  out  1  one-cycle pulse when `start` arrives with an illegal `d_sel`.

## Operation
- Packing: bit j of coefficient i goes to stream bit i·d+j. Stream bit k goes to byte k/8, bit k%8 (LSB first). Because 256·d is always divisible by 8, the stream ends on a byte boundary.
- Registers: `acc[ACC_W-1:0]`, `acc_bits` (0..ACC_W), `coef_cnt` (0..N_COEF), `d_r`.
- FSM states: IDLE, RUN.
- IDLE:
  - `start` with 1≤`d_sel`≤D_MAX clears `acc`, `acc_bits` and `coef_cnt`, latches `d_r`, and moves to RUN.
  - `start` with `d_sel`=0 or `d_sel`>D_MAX pulses `err` for one cycle and stays in IDLE.
- RUN:
  - `byte_valid = (acc_bits >= 8)`.
  - `byte_out = acc[7:0]`.
  - `coef_ready = (coef_cnt < N_COEF) && (acc_bits < 8 || (byte_valid && byte_ready && acc_bits < 16))`.
  - On an emit only: `acc >>= 8`, `acc_bits -= 8`.
  - On an accept only: `acc |= masked << acc_bits`, `acc_bits += d_r`, `coef_cnt++`.
  - On a simultaneous emit and accept: `acc = (acc>>8) | (masked << (acc_bits-8))`, `acc_bits += d_r-8`.
  - `masked = coef_in & ((1<<d_r)-1)`. The upper bits of `coef_in` are ignored.
  - RUN→IDLE when `coef_cnt == N_COEF` and `acc_bits == 0`; `done` pulses in that same transition cycle.
- `start` during RUN is ignored (no restart, no `err`).
- Output stability: while `byte_valid && !byte_ready`, `byte_out` holds and `acc` does not shift out.
- Extra input: `coef_valid` high after the final coefficient is never accepted, because `coef_ready` stays 0.
- Reset: `rst` at any time, including mid-polynomial, forces IDLE and clears all counters and `acc`. Partial output is discarded.

## Timing
- Reset values: `coef_ready`, `byte_valid`, `busy`, `done` and `err` are 0; `byte_out` is 0x00.
- `start` accepted in cycle T → `busy` and `coef_ready` are high in T+1.
- A coefficient accepted in cycle N that brings `acc_bits` to ≥8 → `byte_valid` is high in N+1. There is no combinational path from `coef_in` to `byte_out`.
- Combinational paths: `coef_ready` depends combinationally on `byte_ready`. `byte_valid` is purely registered.
- Throughput with no backpressure: one byte per cycle whenever `d_r`≥8. For `d_r`<8, one coefficient per cycle.
- Total RUN cycles with an always-ready sink and source:
  - `d_r`=12: 384 + 1.
  - `d_r`=1: 256 + 1.
- `done` is asserted exactly one cycle after the handshake of byte 32·d_r−1.

## Configuration
- `ENCODE_MODQ_EN`:
  - Defined: when `d_r`==12, a coefficient with `coef_in >= KYBER_Q` has KYBER_Q subtracted once before masking, giving the canonical representative for inputs below 2q. Other `d_r` values are unaffected.
  - Undefined: no reduction; the coefficient is masked only.

## Test plan
- `d_sel`=12, coefficients 0x123, 0xABC, then 254 zeros, always-ready sink → bytes 0x23, 0xC1, 0xAB, then 381×0x00; `done` pulses once.
- `d_sel`=1, coefficients alternating 1,0 → 32 bytes of 0x55; the 257th `coef_valid` is not accepted.
- `d_sel`=12, `byte_ready` toggled with a 1-in-3 pattern → `byte_out` stays stable while stalled; the byte sequence equals the always-ready run.
- `d_sel`=12, `coef_in`=3330 at index 0:
  - `ENCODE_MODQ_EN` defined → first bytes 0x01, 0x00.
  - `ENCODE_MODQ_EN` undefined → 0x02, 0x0D.
- `start` with `d_sel`=0 → `err` pulses for one cycle, `busy` stays 0. `start` with `d_sel`=4 during RUN → ignored.
- `rst` asserted after 100 bytes of a `d_sel`=10 polynomial → next cycle all outputs are 0; a fresh `start` produces the full 320-byte stream correctly.
